// File: rtl/lsu_axi_lite_master_pkg.sv
// Shared definitions for the LSU AXI-Lite initiator.
//   State encodings S_IDLE..S_RSP, request size codes, AXI response codes,
//   and a helper that flags illegal or misaligned accesses.
package lsu_axi_lite_master_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW_W = 3'd3;
  localparam logic [2:0] S_B    = 3'd4;
  localparam logic [2:0] S_RSP  = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // 1 when the access never reaches the bus: size code 3, odd half, unaligned word.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) || (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_axi_lite_master_if.sv
// Core-side request/response and AXI-Lite bus signals of the LSU initiator.
//   master : view used by lsu_axi_lite_master
//   slave  : view of the environment (core + AXI responder)
interface lsu_axi_lite_master_if #(parameter int ADDR_W = 32);
  logic              req_valid, req_ready, req_write, req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] axi_araddr, axi_awaddr;
  logic              axi_arvalid, axi_arready;
  logic [31:0]       axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid, axi_rready;
  logic              axi_awvalid, axi_awready;
  logic [31:0]       axi_wdata;
  logic [3:0]        axi_wstrb;
  logic              axi_wvalid, axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid, axi_bready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid, axi_awready, axi_wready,
           axi_bresp, axi_bvalid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, axi_araddr, axi_arvalid, axi_rready,
           axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
           axi_arready, axi_rdata, axi_rresp, axi_rvalid, axi_awready, axi_wready,
           axi_bresp, axi_bvalid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, axi_araddr, axi_arvalid, axi_rready,
           axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready
  );
endinterface

// File: rtl/lsu_axi_lite_master_load_align.sv
// lsu_load_align: combinational lane steering for the LSU.
//   i_ld_off/i_ld_size/i_ld_unsigned/i_rdata -> o_ld_data : read data shifted
//     down by the byte offset, then sign/zero-extended per size.
//   i_st_off/i_st_size/i_st_wdata -> o_wdata/o_wstrb : right-aligned store data
//     moved to its byte lanes plus matching strobes.
module lsu_load_align
  import lsu_axi_lite_master_pkg::*;
(
  input  logic [1:0]  i_ld_off,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data,
  input  logic [1:0]  i_st_off,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_wdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);
  logic [31:0] w_sh;

  always_comb begin
    w_sh = i_rdata >> {i_ld_off, 3'b000};
    case (i_ld_size)
      SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'd0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
      SZ_HALF: o_ld_data = i_ld_unsigned ? {16'd0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: o_ld_data = w_sh;
    endcase
    o_wdata = i_st_wdata << {i_st_off, 3'b000};
    case (i_st_size)
      SZ_BYTE: o_wstrb = 4'b0001 << i_st_off;
      SZ_HALF: o_wstrb = 4'b0011 << i_st_off;
      default: o_wstrb = 4'b1111;
    endcase
  end
endmodule

// File: rtl/lsu_axi_lite_master.sv
// lsu_axi_lite_master: single-outstanding AXI-Lite initiator for the MEM-stage LSU.
//   clk, reset (async, active-low) plain ports; all request/response and AXI
//   signals travel on bus (lsu_axi_lite_master_if.master).
//   Optional macro LSU_AXI_TIMEOUT_EN adds a simulation-only watchdog that aborts
//   any AXI phase after TIMEOUT_CYCLES cycles with rsp_err=1.
module lsu_axi_lite_master
  import lsu_axi_lite_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
)(
  input logic                    clk,
  input logic                    reset,
  lsu_axi_lite_master_if.master  bus
);
  logic [2:0]        r_state;
  logic              r_req_ready, r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_rsp_valid, r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic [31:0] w_ld_data, w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic        w_aw_done, w_w_done;

  // Store lanes are computed from the live request and registered at capture;
  // load lanes use the captured offset against the incoming read data.
  lsu_load_align u_align (
    .i_ld_off     (r_addr[1:0]),
    .i_ld_size    (r_size),
    .i_ld_unsigned(r_unsigned),
    .i_rdata      (bus.axi_rdata),
    .o_ld_data    (w_ld_data),
    .i_st_off     (bus.req_addr[1:0]),
    .i_st_size    (bus.req_size),
    .i_st_wdata   (bus.req_wdata),
    .o_wdata      (w_st_wdata),
    .o_wstrb      (w_st_wstrb)
  );

  // A channel counts as done once its valid is gone or handshakes this cycle.
  assign w_aw_done = !r_awvalid || bus.axi_awready;
  assign w_w_done  = !r_wvalid  || bus.axi_wready;

`ifdef LSU_AXI_TIMEOUT_EN
  logic [15:0] r_wait;
  logic        w_wait_st, w_adv, w_timeout;
  assign w_wait_st = (r_state == S_AR) || (r_state == S_R) ||
                     (r_state == S_AW_W) || (r_state == S_B);
  assign w_adv = (r_state == S_AR   && bus.axi_arready) ||
                 (r_state == S_R    && bus.axi_rvalid)  ||
                 (r_state == S_AW_W && w_aw_done && w_w_done) ||
                 (r_state == S_B    && bus.axi_bvalid);
  assign w_timeout = w_wait_st && (r_wait == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_wait <= '0;
    else if (!w_wait_st || w_adv) r_wait <= '0;
    else                         r_wait <= r_wait + 16'd1;
  end
`else
  logic w_unused;
  assign w_unused = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_addr      <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
`ifdef LSU_AXI_TIMEOUT_EN
      if (w_timeout) begin
        $display("lsu_axi_lite_master: watchdog abort addr=%h state=%0d", r_addr, r_state);
        r_arvalid   <= 1'b0;
        r_rready    <= 1'b0;
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_bready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
        r_state     <= S_RSP;
      end else begin
`else
      begin
`endif
        case (r_state)
          S_IDLE: if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_addr      <= bus.req_addr;
            r_size      <= bus.req_size;
            r_unsigned  <= bus.req_unsigned;
            r_wdata     <= w_st_wdata;
            r_wstrb     <= w_st_wstrb;
            if (bad_access(bus.req_size, bus.req_addr[1:0])) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= S_RSP;
            end else if (bus.req_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_AW_W;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
          S_AR: if (bus.axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
          S_R: if (bus.axi_rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= (bus.axi_rresp != RESP_OKAY);
            r_rsp_rdata <= (bus.axi_rresp != RESP_OKAY) ? '0 : w_ld_data;
            r_state     <= S_RSP;
          end
          S_AW_W: begin
            if (bus.axi_awready) r_awvalid <= 1'b0;
            if (bus.axi_wready)  r_wvalid  <= 1'b0;
            if (w_aw_done && w_w_done) begin
              r_bready <= 1'b1;
              r_state  <= S_B;
            end
          end
          S_B: if (bus.axi_bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= (bus.axi_bresp != RESP_OKAY);
            r_rsp_rdata <= '0;
            r_state     <= S_RSP;
          end
          S_RSP: if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.axi_araddr  = r_addr;
  assign bus.axi_arvalid = r_arvalid;
  assign bus.axi_rready  = r_rready;
  assign bus.axi_awaddr  = r_addr;
  assign bus.axi_awvalid = r_awvalid;
  assign bus.axi_wdata   = r_wdata;
  assign bus.axi_wstrb   = r_wstrb;
  assign bus.axi_wvalid  = r_wvalid;
  assign bus.axi_bready  = r_bready;
endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Directed bench for lsu_axi_lite_master: loads, stores, misaligned/illegal
// requests, error responses, response back-pressure and reset mid-transaction.
module tb_lsu_axi_lite_master;
  import lsu_axi_lite_master_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lsu_axi_lite_master_if #(.ADDR_W(32)) bus ();

  lsu_axi_lite_master #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}
  function automatic logic [31:0] flags();
    return {24'd0, bus.req_ready, bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid,
            bus.axi_wvalid, bus.axi_bready, bus.rsp_valid, bus.rsp_err};
  endfunction

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_size = size; bus.req_unsigned = uns; bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Zero-wait read slave; rsp_valid must appear on the 4th cycle counting the accept cycle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic [31:0] exp_data, input logic exp_err);
    issue(1'b0, addr, size, uns, 32'h0);
    chk({tag, " ar flags"}, flags(), 32'h40);
    chk({tag, " araddr"}, bus.axi_araddr, addr);
    bus.axi_arready = 1'b1;
    @(negedge clk);
    bus.axi_arready = 1'b0;
    chk({tag, " r flags"}, flags(), 32'h20);
    bus.axi_rvalid = 1'b1; bus.axi_rdata = rdata; bus.axi_rresp = rresp;
    @(negedge clk);
    bus.axi_rvalid = 1'b0;
    chk({tag, " rsp flags"}, flags(), {30'd0, 1'b1, exp_err});
    chk({tag, " rdata"}, bus.rsp_rdata, exp_data);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " idle"}, flags(), 32'h80);
  endtask

  // Store with awready/wready in the same cycle.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [1:0] bresp,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                          input logic exp_err);
    issue(1'b1, addr, size, 1'b0, wdata);
    chk({tag, " aw/w flags"}, flags(), 32'h18);
    chk({tag, " awaddr"}, bus.axi_awaddr, addr);
    chk({tag, " wdata"}, bus.axi_wdata, exp_wdata);
    chk({tag, " wstrb"}, {28'd0, bus.axi_wstrb}, {28'd0, exp_strb});
    bus.axi_awready = 1'b1; bus.axi_wready = 1'b1;
    @(negedge clk);
    bus.axi_awready = 1'b0; bus.axi_wready = 1'b0;
    chk({tag, " b flags"}, flags(), 32'h04);
    bus.axi_bvalid = 1'b1; bus.axi_bresp = bresp;
    @(negedge clk);
    bus.axi_bvalid = 1'b0;
    chk({tag, " rsp flags"}, flags(), {30'd0, 1'b1, exp_err});
    chk({tag, " rsp rdata"}, bus.rsp_rdata, 32'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " idle"}, flags(), 32'h80);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = '0; bus.req_unsigned = 0; bus.rsp_ready = 0;
    bus.axi_arready = 0; bus.axi_rdata = '0; bus.axi_rresp = '0; bus.axi_rvalid = 0;
    bus.axi_awready = 0; bus.axi_wready = 0; bus.axi_bresp = '0; bus.axi_bvalid = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset flags", flags(), 32'h80);
    chk("reset rdata", bus.rsp_rdata, 32'h0);
    chk("reset araddr", bus.axi_araddr, 32'h0);
    chk("reset wdata", bus.axi_wdata, 32'h0);
    chk("reset wstrb", {28'd0, bus.axi_wstrb}, 32'h0);
    reset = 1'b1;

    // Loads
    do_load("ld b s",   32'h8000_0003, SZ_BYTE, 1'b0, 32'h80AB_CDEF, RESP_OKAY, 32'hFFFF_FF80, 1'b0);
    do_load("ld h u",   32'h8000_0002, SZ_HALF, 1'b1, 32'h9876_1234, RESP_OKAY, 32'h0000_9876, 1'b0);
    do_load("ld w",     32'h8000_0004, SZ_WORD, 1'b0, 32'h1234_5678, RESP_OKAY, 32'h1234_5678, 1'b0);
    do_load("ld h s",   32'h8000_0000, SZ_HALF, 1'b0, 32'h0000_8001, RESP_OKAY, 32'hFFFF_8001, 1'b0);
    do_load("ld b u",   32'h8000_0001, SZ_BYTE, 1'b1, 32'h0000_AB00, RESP_OKAY, 32'h0000_00AB, 1'b0);
    do_load("ld slverr", 32'h8000_000C, SZ_WORD, 1'b0, 32'hCAFE_F00D, RESP_SLVERR, 32'h0, 1'b1);

    // Stores, both channels ready together
    do_store("st w err", 32'h1000_0004, SZ_WORD, 32'hDEAD_BEEF, RESP_SLVERR, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    do_store("st b",     32'h1000_0001, SZ_BYTE, 32'h0000_00A5, RESP_OKAY,   32'h0000_A500, 4'b0010, 1'b0);

    // Store half, awready two cycles ahead of wready; stray request mid-flight ignored
    issue(1'b1, 32'hA000_03FA, SZ_HALF, 1'b0, 32'h0000_BEEF);
    chk("st h flags", flags(), 32'h18);
    chk("st h wdata", bus.axi_wdata, 32'hBEEF_0000);
    chk("st h wstrb", {28'd0, bus.axi_wstrb}, 32'h0000_000C);
    chk("st h awaddr", bus.axi_awaddr, 32'hA000_03FA);
    bus.axi_awready = 1'b1;
    @(negedge clk);
    bus.axi_awready = 1'b0;
    chk("st h aw dropped", flags(), 32'h08);
    bus.req_valid = 1'b1; bus.req_addr = 32'h1234_5678; bus.req_write = 1'b0;
    @(negedge clk);
    chk("st h w held", flags(), 32'h08);
    chk("st h ignore req", bus.axi_awaddr, 32'hA000_03FA);
    bus.axi_wready = 1'b1;
    @(negedge clk);
    bus.axi_wready = 1'b0; bus.req_valid = 1'b0;
    chk("st h b", flags(), 32'h04);
    bus.axi_bvalid = 1'b1; bus.axi_bresp = RESP_OKAY;
    @(negedge clk);
    bus.axi_bvalid = 1'b0;
    chk("st h rsp", flags(), 32'h02);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("st h idle", flags(), 32'h80);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("st h single rsp", flags(), 32'h80);

    // Misaligned word load: error next cycle, no AR traffic
    issue(1'b0, 32'h8000_0001, SZ_WORD, 1'b0, 32'h0);
    chk("misal w", flags(), 32'h03);
    chk("misal rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    chk("misal hold", flags(), 32'h03);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("misal idle", flags(), 32'h80);

    // Illegal size on an aligned store: no AW/W traffic
    issue(1'b1, 32'h1000_0000, SZ_ILL, 1'b0, 32'h1111_2222);
    chk("size3", flags(), 32'h03);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("size3 idle", flags(), 32'h80);

    // rresp=01 with response back-pressure for 5 cycles
    issue(1'b0, 32'h8000_0008, SZ_WORD, 1'b0, 32'h0);
    bus.axi_arready = 1'b1;
    @(negedge clk);
    bus.axi_arready = 1'b0;
    bus.axi_rvalid = 1'b1; bus.axi_rdata = 32'hFFFF_FFFF; bus.axi_rresp = 2'b01;
    @(negedge clk);
    bus.axi_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rresp01 hold%0d", i), flags(), 32'h03);
      chk($sformatf("rresp01 rdata%0d", i), bus.rsp_rdata, 32'h0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rresp01 idle", flags(), 32'h80);

    // Reset asserted while AR is pending
    issue(1'b0, 32'h8000_0010, SZ_WORD, 1'b0, 32'h0);
    chk("mid-ar pending", flags(), 32'h40);
    reset = 1'b0;
    #1;
    chk("mid-ar reset flags", flags(), 32'h80);
    chk("mid-ar reset addr", bus.axi_araddr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    do_load("post-rst ld", 32'h8000_0014, SZ_WORD, 1'b0, 32'h0BAD_CAFE, RESP_OKAY, 32'h0BAD_CAFE, 1'b0);

`ifdef LSU_AXI_TIMEOUT_EN
    // Watchdog: arready never arrives
    begin
      int ar_cycles;
      ar_cycles = 0;
      issue(1'b0, 32'h8000_0020, SZ_WORD, 1'b0, 32'h0);
      for (int i = 0; i < 40; i++) begin
        if (bus.rsp_valid) break;
        if (bus.axi_arvalid) ar_cycles++;
        @(negedge clk);
      end
      chk("timeout ar cycles", ar_cycles, 32'd16);
      chk("timeout flags", flags(), 32'h03);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("timeout idle", flags(), 32'h80);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
